// File: rtl/branch_cond_unit_if.sv
// Branch-condition bus: FLAG read port, flag-writer tracking strobes,
// decode branch request and the registered PC-select result.
interface branch_cond_unit_if #(
    parameter int PC_WIDTH = 16
);
  logic [2:0]          FlagIn;
  logic                FlagReadEnable;
  logic                FlagIssue;
  logic                FlagRetire;
  logic                BrValid;
  logic [2:0]          BrCond;
  logic [PC_WIDTH-1:0] BrTarget;
  logic [PC_WIDTH-1:0] PcPlus2;
  logic                Stall;
  logic                BrDone;
  logic                BrTaken;
  logic [PC_WIDTH-1:0] NextPc;
  logic                PendErr;

  modport master (
    output FlagIn, FlagIssue, FlagRetire, BrValid, BrCond, BrTarget, PcPlus2,
    input  FlagReadEnable, Stall, BrDone, BrTaken, NextPc, PendErr
  );

  modport slave (
    input  FlagIn, FlagIssue, FlagRetire, BrValid, BrCond, BrTarget, PcPlus2,
    output FlagReadEnable, Stall, BrDone, BrTaken, NextPc, PendErr
  );
endinterface

// File: rtl/branch_cond_unit.sv
// Holds a branch until all in-flight flag writers have retired, then reads the
// FLAG register, evaluates the condition code and returns taken / next PC.
module branch_cond_unit #(
    parameter int MAX_PENDING = 3,
    parameter int PC_WIDTH    = 16
) (
    input logic                clk,
    input logic                rst,
    branch_cond_unit_if.slave  bus
);
  localparam int CW = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EVAL = 2'd2
  } stateT;

  stateT               stateR;
  stateT               nextStateS;
  logic [CW-1:0]       pendingR;
  logic [CW-1:0]       pendingNextS;
  logic                pendFaultS;
  logic                acceptS;
  logic                takenS;
  logic [2:0]          condR;
  logic [PC_WIDTH-1:0] targetR;
  logic [PC_WIDTH-1:0] fallR;
  logic                doneR;
  logic                takenR;
  logic [PC_WIDTH-1:0] nextPcR;
  logic                errR;

  // Flag layout: [2]=Z [1]=V [0]=N; 3'b111 is unconditional.
  function automatic logic condMet(input logic [2:0] cc, input logic [2:0] flags);
    logic z;
    logic v;
    logic n;
    z = flags[2];
    v = flags[1];
    n = flags[0];
    case (cc)
      3'b000:  condMet = ~z;
      3'b001:  condMet = z;
      3'b010:  condMet = ~z & ~n;
      3'b011:  condMet = n;
      3'b100:  condMet = z | ~n;
      3'b101:  condMet = z | n;
      3'b110:  condMet = v;
      default: condMet = 1'b1;
    endcase
  endfunction

  // Saturating pending-writer count; over/underflow holds the count and raises a fault.
  always_comb begin
    pendingNextS = pendingR;
    pendFaultS   = 1'b0;
    if (bus.FlagIssue && !bus.FlagRetire) begin
      if (pendingR == CW'(MAX_PENDING)) begin
        pendFaultS = 1'b1;
      end else begin
        pendingNextS = pendingR + CW'(1);
      end
    end else if (bus.FlagRetire && !bus.FlagIssue) begin
      if (pendingR == {CW{1'b0}}) begin
        pendFaultS = 1'b1;
      end else begin
        pendingNextS = pendingR - CW'(1);
      end
    end else begin
      pendingNextS = pendingR;
    end
  end

  // Next-state logic; the cycle carrying BrDone never accepts a new request.
  always_comb begin
    nextStateS = stateR;
    acceptS    = 1'b0;
    case (stateR)
      IDLE: begin
        if (bus.BrValid && !doneR) begin
          acceptS = 1'b1;
          if (bus.BrCond == 3'b111 || pendingNextS == {CW{1'b0}}) begin
            nextStateS = EVAL;
          end else begin
            nextStateS = WAIT;
          end
        end else begin
          nextStateS = IDLE;
        end
      end
      WAIT: begin
        if (pendingNextS == {CW{1'b0}}) begin
          nextStateS = EVAL;
        end else begin
          nextStateS = WAIT;
        end
      end
      EVAL:    nextStateS = IDLE;
      default: nextStateS = IDLE;
    endcase
  end

  assign takenS             = condMet(condR, bus.FlagIn);
  assign bus.FlagReadEnable = (stateR == EVAL);
  assign bus.Stall          = ((stateR == IDLE) && bus.BrValid && !doneR) ||
                              (stateR == WAIT) || (stateR == EVAL);
  assign bus.BrDone         = doneR;
  assign bus.BrTaken        = takenR;
  assign bus.NextPc         = nextPcR;
  assign bus.PendErr        = errR;

  // State, pending count and sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR   <= IDLE;
      pendingR <= {CW{1'b0}};
      errR     <= 1'b0;
    end else begin
      stateR   <= nextStateS;
      pendingR <= pendingNextS;
      if (pendFaultS) begin
        errR <= 1'b1;
      end
    end
  end

  // Request latch and registered branch result; result holds until the next EVAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      condR   <= 3'b000;
      targetR <= {PC_WIDTH{1'b0}};
      fallR   <= {PC_WIDTH{1'b0}};
      doneR   <= 1'b0;
      takenR  <= 1'b0;
      nextPcR <= {PC_WIDTH{1'b0}};
    end else begin
      if (acceptS) begin
        condR   <= bus.BrCond;
        targetR <= bus.BrTarget;
        fallR   <= bus.PcPlus2;
      end
      doneR <= (stateR == EVAL);
      if (stateR == EVAL) begin
        takenR  <= takenS;
        nextPcR <= takenS ? targetR : fallR;
      end
    end
  end
endmodule
